avr_dm_ext_bridge: RTL and testbench
====================================

// Module: avr_dm_ext_bridge
// PURPOSE
//  Parametrised external data-memory bridge between the AVR interconnect DM master side and up to NUM_WIN
//  external byte-wide slaves (SRAM, mailbox, CD buffer). Decodes address windows, generates per-window
//  chip selects, per-window wait states, slave wait-stretching and a timeout abort. Drives the core stall
//  (busy) and the read-data/out_en pair consumed by the interconnect read mux.
// PARAMETERS
//  NUM_WIN   2                  number of external windows (1..8)
//  WIN_BASE  {16'hF000,16'hE000} packed 16b bases, window i at [16*i+:16]
//  WIN_SIZE  {16'h0400,16'h0400} packed 16b sizes in bytes (power of two, base aligned to size)
//  WIN_WS    {4'd2,4'd0}        packed 4b fixed wait states per window
//  EXT_AW    16                 external address width (offset within window, LSBs)
//  TIMEOUT   255                max ACC cycles before abort (8b, 0 = disabled)
// PORTS
//  clk       in   1        system clock; all state on rising edge
//  nrst      in   1        reset: asynchronous, active-low
//  ramadr    in   16       DM address from interconnect
//  ramre     in   1        DM read strobe
//  ramwe     in   1        DM write strobe
//  ramdout   in   8        DM write data
//  busy      out  1        stall to core (cpuwait contribution)
//  out_en    out  1        read data valid for interconnect mux
//  rdata     out  8        read data to interconnect
//  ext_a     out  EXT_AW   window-relative address
//  ext_d_out out  8        write data to slave
//  ext_d_in  in   8*NUM_WIN  per-window read data, window i at [8*i+:8]
//  ext_cs    out  NUM_WIN  one-hot chip select
//  ext_oe    out  1        read enable
//  ext_we    out  1        write enable
//  ext_wait  in   NUM_WIN  per-window slave stretch request
//  err       out  1        sticky timeout flag
//  err_clr   in   1        clears err (one cycle pulse)
// BEHAVIOUR
//  - Reset: state IDLE, busy=0, out_en=0, rdata=0, ext_cs=0, ext_oe=0, ext_we=0, ext_a=0, ext_d_out=0, err=0.
//    Reset mid-access aborts immediately; all strobes drop asynchronously.
//  - Decode (comb): hit_i = (ramadr & ~(SIZE_i-1)) == BASE_i; overlapping windows: lowest index wins.
//  - FSM IDLE/ACC/DONE. Cycle T0: IDLE & (ramre|ramwe) & hit -> busy=1 combinationally, register ch,
//    ext_a=ramadr-BASE_ch, ext_d_out=ramdout, cnt=WS_ch, tmo=0; next ACC.
//  - ACC: ext_cs[ch]=1, ext_oe=rd, ext_we=wr (registered, glitch-free); busy=1. cnt decrements each cycle
//    to 0; leave when cnt==0 & !ext_wait[ch] -> DONE, capturing rdata=ext_d_in[ch] on reads.
//  - DONE: strobes low, busy=0, out_en=1 for reads; core completes this cycle; next IDLE unconditionally
//    (core request still present in DONE must not restart an access).
//  - Latency: busy high WS+2 cycles with ext_wait low; each ext_wait cycle adds one. WS=0 -> T0,T1 busy, T2 done.
//  - ramre & ramwe together: write wins, ext_oe stays 0.
//  - Timeout: tmo counts ACC cycles; at tmo==TIMEOUT (TIMEOUT!=0) force DONE, rdata=8'hFF, err<=1.
//    err_clr same cycle as new timeout: set wins.
//  - Miss or no strobe in IDLE: busy=0, out_en=0, no external activity.
//  - ext_a/ext_d_out hold last values between accesses.
// STRUCTURE
//  - avr_ext_bridge_def.vh: state encodings (IDLE=2'd0, ACC=2'd1, DONE=2'd2), RDATA_ABORT=8'hFF.
//  - Sub-module avr_ext_win_dec: combinational window decoder (NUM_WIN, WIN_BASE, WIN_SIZE) ->
//    hit, ch index, offset. Reused by the IO-space variant.
//  - Top holds FSM, wait/timeout counters, output registers.
// TESTING
//  - Read win0 (WS=0) @16'hE010, ext_d_in[7:0]=8'h5A -> cs[0] 1 cycle, busy 2 cycles, rdata=8'h5A, out_en 1 cycle.
//  - Write win1 (WS=2) @16'hF3FF data 8'hC3 -> ext_a=16'h03FF, ext_we 3 cycles, busy 4 cycles, cs=2'b10.
//  - Win0 with ext_wait high 5 cycles -> busy 7 cycles, strobes held stable throughout.
//  - TIMEOUT=8, ext_wait stuck high -> abort after 8 ACC cycles, rdata=8'hFF, err=1; err_clr -> err=0.
//  - Read @16'h0100 (miss) -> busy=0, out_en=0, cs=0; nrst low mid-ACC -> all outputs reset same cycle.
//  - Back-to-back reads win0 then win1 -> second access starts cycle after DONE, no overlapping cs.

Source files
------------

// File: rtl/avr_dm_ext_bridge_pkg.sv
// Shared definitions for the external data-memory bridge and its window decoder.
// Holds the FSM state encoding, the abort read value and a channel-width helper.
package avr_dm_ext_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] RDATA_ABORT = 8'hFF;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/avr_ext_win_dec.sv
// Combinational address-window decoder: hit flag, winning window index and offset.
// Windows are power-of-two sized and aligned; on overlap the lowest index wins.
module avr_ext_win_dec
    import avr_dm_ext_bridge_pkg::*;
#(
    parameter int                    NUM_WIN  = 2,
    parameter logic [16*NUM_WIN-1:0] WIN_BASE = {16'hF000, 16'hE000},
    parameter logic [16*NUM_WIN-1:0] WIN_SIZE = {16'h0400, 16'h0400},
    localparam int                   CH_W     = ch_width(NUM_WIN)
) (
    input  logic [15:0]     addr,
    output logic            hit,
    output logic [CH_W-1:0] ch,
    output logic [15:0]     offset
);

    // Scan from the top index down so the last match written is the lowest index.
    always_comb begin
        hit    = 1'b0;
        ch     = '0;
        offset = '0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if ((addr & ~(WIN_SIZE[16*i +: 16] - 16'd1)) == WIN_BASE[16*i +: 16]) begin
                hit    = 1'b1;
                ch     = CH_W'(i);
                offset = addr - WIN_BASE[16*i +: 16];
            end
        end
    end

endmodule

// File: rtl/avr_dm_ext_bridge.sv
// Bridge from the AVR DM master side to NUM_WIN external byte-wide slaves with
// per-window wait states, slave wait-stretching, timeout abort and sticky error.
module avr_dm_ext_bridge
    import avr_dm_ext_bridge_pkg::*;
#(
    parameter int                    NUM_WIN  = 2,
    parameter logic [16*NUM_WIN-1:0] WIN_BASE = {16'hF000, 16'hE000},
    parameter logic [16*NUM_WIN-1:0] WIN_SIZE = {16'h0400, 16'h0400},
    parameter logic [4*NUM_WIN-1:0]  WIN_WS   = {4'd2, 4'd0},
    parameter int                    EXT_AW   = 16,
    parameter int                    TIMEOUT  = 255
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [15:0]          ramadr,
    input  logic                 ramre,
    input  logic                 ramwe,
    input  logic [7:0]           ramdout,
    output logic                 busy,
    output logic                 out_en,
    output logic [7:0]           rdata,
    output logic [EXT_AW-1:0]    ext_a,
    output logic [7:0]           ext_d_out,
    input  logic [8*NUM_WIN-1:0] ext_d_in,
    output logic [NUM_WIN-1:0]   ext_cs,
    output logic                 ext_oe,
    output logic                 ext_we,
    input  logic [NUM_WIN-1:0]   ext_wait,
    output logic                 err,
    input  logic                 err_clr
);

    localparam int         CH_W    = ch_width(NUM_WIN);
    localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

    state_t            state, state_nxt;
    logic              dec_hit;
    logic [CH_W-1:0]   dec_ch;
    logic [15:0]       dec_off;
    logic [CH_W-1:0]   ch;
    logic              rd;
    logic [3:0]        cnt;
    logic [7:0]        tmo;
    logic [7:0]        tmo_nxt;
    logic              start;
    logic              done_ok;
    logic              abort;
    logic              acc_end;

    avr_ext_win_dec #(
        .NUM_WIN  (NUM_WIN),
        .WIN_BASE (WIN_BASE),
        .WIN_SIZE (WIN_SIZE)
    ) u_dec (
        .addr   (ramadr),
        .hit    (dec_hit),
        .ch     (dec_ch),
        .offset (dec_off)
    );

    assign start   = (state == ST_IDLE) && (ramre || ramwe) && dec_hit;
    assign tmo_nxt = tmo + 8'd1;
    assign done_ok = (cnt == 4'd0) && !ext_wait[ch];
    // tmo_nxt is the number of ACC cycles including this one; a normal finish beats the abort.
    assign abort   = !done_ok && (TMO_LIM != 8'd0) && (tmo_nxt == TMO_LIM);
    assign acc_end = done_ok || abort;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    busy      = 1'b1;
                    state_nxt = ST_ACC;
                end
            end
            ST_ACC: begin
                busy = 1'b1;
                if (acc_end) state_nxt = ST_DONE;
            end
            // The core still holds its strobe here; DONE never restarts an access.
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ch        <= '0;
            rd        <= 1'b0;
            cnt       <= '0;
            tmo       <= '0;
            ext_a     <= '0;
            ext_d_out <= '0;
            ext_cs    <= '0;
            ext_oe    <= 1'b0;
            ext_we    <= 1'b0;
            rdata     <= '0;
            out_en    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    out_en <= 1'b0;
                    if (start) begin
                        ch        <= dec_ch;
                        rd        <= ramre && !ramwe;
                        cnt       <= WIN_WS[4*dec_ch +: 4];
                        tmo       <= '0;
                        ext_a     <= EXT_AW'(dec_off);
                        ext_d_out <= ramdout;
                        ext_cs    <= NUM_WIN'(1) << dec_ch;
                        ext_oe    <= ramre && !ramwe;
                        ext_we    <= ramwe;
                    end
                end
                ST_ACC: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                    tmo <= tmo_nxt;
                    if (acc_end) begin
                        ext_cs <= '0;
                        ext_oe <= 1'b0;
                        ext_we <= 1'b0;
                        out_en <= rd;
                        if (abort)   rdata <= RDATA_ABORT;
                        else if (rd) rdata <= ext_d_in[8*ch +: 8];
                    end
                end
                default: out_en <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)                            err <= 1'b0;
        else if ((state == ST_ACC) && abort)  err <= 1'b1;
        else if (err_clr)                     err <= 1'b0;
    end

endmodule

// File: tb/tb_avr_dm_ext_bridge.sv
// Randomised bench for avr_dm_ext_bridge against a transaction-level reference model.
// Each access is summarised (busy/cs/strobe cycle counts, data) and compared to the model.
module tb_avr_dm_ext_bridge;

    localparam int NW  = 2;
    localparam int TMO = 8;

    logic              clk = 1'b0;
    logic              nrst;
    logic [15:0]       ramadr;
    logic              ramre, ramwe;
    logic [7:0]        ramdout;
    logic              busy, out_en;
    logic [7:0]        rdata;
    logic [15:0]       ext_a;
    logic [7:0]        ext_d_out;
    logic [8*NW-1:0]   ext_d_in;
    logic [NW-1:0]     ext_cs;
    logic              ext_oe, ext_we;
    logic [NW-1:0]     ext_wait;
    logic              err, err_clr;

    int total = 0;
    int bad   = 0;

    int base_m [NW] = '{32'hE000, 32'hF000};
    int size_m [NW] = '{32'h0400, 32'h0400};
    int ws_m   [NW] = '{0, 2};

    logic [15:0] ext_a_m;
    logic [7:0]  dout_m;
    bit          err_m;
    logic [15:0] edges [8] = '{16'hDFFF, 16'hE3FF, 16'hE400, 16'hEFFF,
                               16'hF000, 16'hF3FF, 16'hF400, 16'hFFFF};

    avr_dm_ext_bridge #(
        .NUM_WIN  (NW),
        .WIN_BASE ({16'hF000, 16'hE000}),
        .WIN_SIZE ({16'h0400, 16'h0400}),
        .WIN_WS   ({4'd2, 4'd0}),
        .EXT_AW   (16),
        .TIMEOUT  (TMO)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .ramadr    (ramadr),
        .ramre     (ramre),
        .ramwe     (ramwe),
        .ramdout   (ramdout),
        .busy      (busy),
        .out_en    (out_en),
        .rdata     (rdata),
        .ext_a     (ext_a),
        .ext_d_out (ext_d_out),
        .ext_d_in  (ext_d_in),
        .ext_cs    (ext_cs),
        .ext_oe    (ext_oe),
        .ext_we    (ext_we),
        .ext_wait  (ext_wait),
        .err       (err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One core access: strobes held until busy drops, slave wait driven per ACC cycle from wpat.
    task automatic txn(input logic [15:0] a, input bit re, input bit we, input logic [7:0] wd,
                       input logic [15:0] din, input logic [31:0] wpat, input bit clr_acc,
                       input bit gap);
        bit hit, abrt, fin, rdop;
        int ch, n, cyc, busy_c, cs_c, oe_c, we_c, oen_c, unst;
        logic [15:0] off;
        logic [NW-1:0] cs_or;
        logic [NW+1:0] first;
        logic [7:0] rd_seen;

        hit = 0; ch = 0; off = 0; n = 0; abrt = 0;
        for (int i = 0; i < NW; i++)
            if (!hit && int'(a) >= base_m[i] && int'(a) < base_m[i] + size_m[i]) begin
                hit = 1; ch = i; off = 16'(int'(a) - base_m[i]);
            end
        hit  = hit && (re || we);
        rdop = re && !we;
        if (hit)
            for (int k = 0; k < 32; k++) begin
                if (k >= ws_m[ch] && !wpat[k]) begin n = k + 1; break; end
                if (k + 1 == TMO) begin n = k + 1; abrt = 1; break; end
            end

        busy_c = 0; cs_c = 0; oe_c = 0; we_c = 0; oen_c = 0; unst = 0;
        cs_or = '0; first = '0; rd_seen = '0; fin = 0; cyc = 0;
        @(posedge clk); #1;
        ramadr = a; ramre = re; ramwe = we; ramdout = wd; ext_d_in = din;
        while (!fin && cyc < 40) begin
            if (cyc > 0) begin @(posedge clk); #1; end
            ext_wait = NW'($urandom);
            err_clr  = 1'b0;
            if (ext_cs != '0) begin
                ext_wait[ch] = wpat[cs_c];
                err_clr      = clr_acc;
            end
            @(negedge clk);
            if (busy) busy_c++;
            if (ext_cs != '0) begin
                if (cs_c == 0) first = {ext_cs, ext_oe, ext_we};
                else if ({ext_cs, ext_oe, ext_we} != first) unst++;
                cs_c++;
                cs_or |= ext_cs;
            end
            if (ext_oe) oe_c++;
            if (ext_we) we_c++;
            if (out_en) begin oen_c++; rd_seen = rdata; end
            if (!busy) fin = 1;
            cyc++;
        end
        chk("bound", 32'(fin), 1);
        chk("busy_cycles", busy_c, hit ? n + 1 : 0);
        chk("cs_cycles", cs_c, hit ? n : 0);
        chk("cs_onehot", 32'(cs_or), hit ? (1 << ch) : 0);
        chk("oe_cycles", oe_c, (hit && rdop) ? n : 0);
        chk("we_cycles", we_c, (hit && we) ? n : 0);
        chk("strobe_stable", unst, 0);
        chk("out_en_cycles", oen_c, (hit && rdop) ? 1 : 0);
        if (hit && rdop) chk("rdata", 32'(rd_seen), abrt ? 32'hFF : 32'(din[8*ch +: 8]));
        if (hit) begin
            ext_a_m = off;
            dout_m  = wd;
            if (abrt) err_m = 1;
            else if (clr_acc) err_m = 0;
        end
        chk("ext_a", 32'(ext_a), 32'(ext_a_m));
        chk("ext_d_out", 32'(ext_d_out), 32'(dout_m));
        chk("err", 32'(err), 32'(err_m));
        if (gap) begin
            @(posedge clk); #1;
            ramre = 0; ramwe = 0; err_clr = 0;
            @(negedge clk);
            chk("after_done_busy", 32'(busy), 0);
            chk("after_done_cs", 32'(ext_cs), 0);
        end
    endtask

    task automatic clear_err();
        @(posedge clk); #1;
        ramre = 0; ramwe = 0; err_clr = 1;
        @(posedge clk); #1;
        err_clr = 0;
        @(negedge clk);
        err_m = 0;
        chk("err_clr", 32'(err), 0);
    endtask

    task automatic reset_mid_acc();
        @(posedge clk); #1;
        ramadr = 16'hE020; ramre = 1; ramwe = 0; ext_wait = '1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_cs", 32'(ext_cs), 1);
        ramre = 0; nrst = 0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_strobes", 32'({ext_cs, ext_oe, ext_we}), 0);
        chk("rst_data", 32'({out_en, rdata, err}), 0);
        chk("rst_addr", 32'({ext_a, ext_d_out}), 0);
        @(negedge clk);
        nrst = 1; ext_wait = '0;
        ext_a_m = 0; dout_m = 0; err_m = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=stuck exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        nrst = 0; ramadr = 0; ramre = 0; ramwe = 0; ramdout = 0;
        ext_d_in = 0; ext_wait = 0; err_clr = 0;
        ext_a_m = 0; dout_m = 0; err_m = 0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_strobes", 32'({ext_cs, ext_oe, ext_we}), 0);
        chk("reset_data", 32'({out_en, rdata, err}), 0);
        chk("reset_addr", 32'({ext_a, ext_d_out}), 0);
        nrst = 1;

        txn(16'hE010, 1, 0, 8'h00, 16'h775A, 32'h0, 0, 1);
        txn(16'hF3FF, 0, 1, 8'hC3, 16'h1234, 32'h0, 0, 1);
        txn(16'hE000, 1, 0, 8'h11, 16'h00A5, 32'h1F, 0, 1);
        txn(16'hF123, 1, 0, 8'h22, 16'h3C00, 32'hFFFF_FFFF, 0, 1);
        clear_err();
        txn(16'h0100, 1, 0, 8'h33, 16'hFFFF, 32'h0, 0, 1);
        txn(16'hE3FF, 1, 1, 8'h44, 16'hBEEF, 32'h0, 0, 1);
        txn(16'hE004, 1, 0, 8'h55, 16'h0066, 32'h0, 0, 0);
        txn(16'hF004, 1, 0, 8'h66, 16'h9900, 32'h2, 0, 1);
        txn(16'hE200, 1, 0, 8'h77, 16'h0012, 32'hFFFF_FFFF, 1, 1);
        txn(16'hF200, 0, 1, 8'h88, 16'h0000, 32'h0, 1, 1);
        reset_mid_acc();

        for (int t = 0; t < 50; t++) begin
            logic [31:0] wp;
            case ($urandom_range(0, 3))
                0:       a = 16'hE000 + 16'($urandom_range(0, 16'h3FF));
                1:       a = 16'hF000 + 16'($urandom_range(0, 16'h3FF));
                2:       a = 16'($urandom);
                default: a = edges[$urandom_range(0, 7)];
            endcase
            wp = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : ($urandom & $urandom);
            txn(a, 1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom), wp,
                $urandom_range(0, 5) == 0, 1'($urandom));
            if ($urandom_range(0, 9) == 0) clear_err();
        end

        @(posedge clk); #1;
        ramre = 0; ramwe = 0; err_clr = 0;
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
